// File: rtl/difftest_commit_collector.sv
// Difftest commit collector: queues ROB commit lanes in program order
// and presents one InstrCommit record per cycle to the sink.
module difftest_commit_collector #(
  parameter  int IN_LANES = 2,
  parameter  int DEPTH    = 16,
  parameter  int CORE_ID  = 0,
  localparam int REC_W    = 150,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [IN_LANES-1:0]       in_valid,
  input  logic [IN_LANES*REC_W-1:0] in_rec,
  output logic                      in_ready,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [REC_W-1:0]          out_rec,
  output logic [7:0]                out_index,
  output logic [7:0]                out_coreid,
  output logic [CW-1:0]             count,
  output logic                      ovf_err
);

  localparam int EW = REC_W + 3;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW-1:0] waddr [IN_LANES];
  logic [CW-1:0] npush;
  logic [CW-1:0] nadd;
  logic          any_v;
  logic          push;
  logic          pop;

  // Threshold uses registered occupancy only; a same-cycle pop is ignored.
  assign in_ready = count_q <= CW'(DEPTH - IN_LANES);
  assign any_v    = |in_valid;
  assign push     = any_v & in_ready;
  assign pop      = out_valid & out_ready;

  // Compact valid lanes: each lane lands after all older valid lanes.
  always_comb begin
    npush = '0;
    for (int k = 0; k < IN_LANES; k++) begin
      waddr[k] = tail_q + npush[AW-1:0];
      if (in_valid[k]) npush = npush + CW'(1);
    end
  end

  always_comb begin
    nadd    = push ? npush : '0;
    tail_d  = tail_q + nadd[AW-1:0];
    head_d  = head_q + AW'(pop);
    count_d = count_q + nadd - CW'(pop);
    ovf_d   = ovf_q | (any_v & ~in_ready);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clock) begin
    if (push) begin
      for (int k = 0; k < IN_LANES; k++) begin
        if (in_valid[k])
          mem_q[waddr[k]] <= {3'(k), in_rec[k*REC_W +: REC_W]};
      end
    end
  end

  assign out_valid  = count_q != '0;
  assign out_rec    = mem_q[head_q][REC_W-1:0];
  assign out_index  = {5'b0, mem_q[head_q][REC_W +: 3]};
  assign out_coreid = 8'(CORE_ID);
  assign count      = count_q;
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_difftest_commit_collector.sv
// Scoreboard bench for difftest_commit_collector: a queue model of the
// commit stream is checked against the DUT head every cycle.
module tb_difftest_commit_collector;

  localparam int L  = 2;
  localparam int D  = 16;
  localparam int RW = 150;
  localparam int CW = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [L-1:0]    in_valid = '0;
  logic [L*RW-1:0] in_rec = '0;
  logic            in_ready;
  logic            out_ready = 1'b0;
  logic            out_valid;
  logic [RW-1:0]   out_rec;
  logic [7:0]      out_index;
  logic [7:0]      out_coreid;
  logic [CW-1:0]   count;
  logic            ovf_err;

  difftest_commit_collector #(
    .IN_LANES(L), .DEPTH(D), .CORE_ID(0)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_rec(in_rec), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_rec(out_rec),
    .out_index(out_index), .out_coreid(out_coreid),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clock = ~clock;

  typedef logic [RW+2:0] ent_t;

  ent_t exp_q[$];
  ent_t pend_q[$];
  bit   exp_ovf  = 1'b0;
  bit   pend_ovf = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(input string nm, input logic [159:0] act,
                     input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  function automatic logic [RW-1:0] rnd_rec();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[RW-1:0];
  endfunction

  function automatic logic [RW-1:0] mk(input logic [63:0] pc,
                                       input logic [31:0] ins,
                                       input logic [9:0] rob);
    logic [RW-1:0] r;
    r = rnd_rec();
    r[63:0]   = pc;
    r[95:64]  = ins;
    r[105:96] = rob;
    return r;
  endfunction

  // Monitor: compare the head against the oldest expected record.
  always @(negedge clock) begin
    if (!reset) begin
      chk("count", 160'(count), 160'(exp_q.size()));
      chk("out_valid", 160'(out_valid), 160'(exp_q.size() != 0));
      chk("in_ready", 160'(in_ready), 160'(exp_q.size() <= D - L));
      chk("ovf_err", 160'(ovf_err), 160'(exp_ovf));
      chk("coreid", 160'(out_coreid), 160'(0));
      if (exp_q.size() != 0) begin
        chk("out_rec", 160'(out_rec), 160'(exp_q[0][RW-1:0]));
        chk("out_index", 160'(out_index), 160'(exp_q[0][RW +: 3]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // One cycle of stimulus; the previous cycle's accepted lanes are
  // appended to the model right after the edge that stored them.
  task automatic drive(input logic [L-1:0] v, input logic [L*RW-1:0] r,
                       input logic ordy);
    @(posedge clock);
    #1;
    while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    exp_ovf  = exp_ovf | pend_ovf;
    pend_ovf = 1'b0;
    in_valid  = v;
    in_rec    = r;
    out_ready = ordy;
    if (v != '0) begin
      if (exp_q.size() <= D - L) begin
        for (int k = 0; k < L; k++)
          if (v[k]) pend_q.push_back({3'(k), r[k*RW +: RW]});
      end else begin
        pend_ovf = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive('0, '0, ordy);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    in_valid  = '0;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_count", 160'(count), 160'(0));
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_ovf", 160'(ovf_err), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    exp_q.delete();
    pend_q.delete();
    exp_ovf  = 1'b0;
    pend_ovf = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [RW-1:0] r0;
    logic [RW-1:0] r1;
    #1;
    chk("init_out_valid", 160'(out_valid), 160'(0));
    chk("init_in_ready", 160'(in_ready), 160'(1));
    chk("init_count", 160'(count), 160'(0));
    chk("init_index", 160'(out_index), 160'(0));
    chk("init_ovf", 160'(ovf_err), 160'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single lane-0 commit.
    r0 = mk(64'h8000_0000, 32'h0000_0013, 10'd0);
    drive(2'b01, {{RW{1'b0}}, r0}, 1'b0);
    idle(3, 1'b1);

    // Two-lane burst, ascending pcs.
    for (int i = 0; i < 4; i++) begin
      r0 = mk(64'h8000_1000 + 64'(8 * i), 32'h13, 10'(2 * i));
      r1 = mk(64'h8000_1004 + 64'(8 * i), 32'h13, 10'(2 * i + 1));
      drive(2'b11, {r1, r0}, 1'b1);
    end
    idle(8, 1'b1);

    // Lane 1 alone.
    r1 = mk(64'h8000_2000, 32'h13, 10'h3FF);
    drive(2'b10, {r1, {RW{1'b0}}}, 1'b0);
    idle(3, 1'b1);

    // Fill to 15, then overflow.
    for (int i = 0; i < 7; i++) drive(2'b11, {rnd_rec(), rnd_rec()}, 1'b0);
    drive(2'b01, {rnd_rec(), rnd_rec()}, 1'b0);
    drive(2'b11, {rnd_rec(), rnd_rec()}, 1'b0);
    idle(2, 1'b0);
    idle(20, 1'b1);
    do_reset();

    // Continuous single-lane stream across pointer wrap.
    for (int i = 0; i < 40; i++)
      drive(2'b01, {rnd_rec(), mk(64'(i) * 4, 32'h13, 10'(i))}, 1'b1);
    idle(4, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      drive(L'($urandom), {rnd_rec(), rnd_rec()}, 1'($urandom_range(0, 2) != 0));
    idle(20, 1'b1);
    do_reset();

    // Reach count 7, then reset mid-stream.
    for (int i = 0; i < 3; i++) drive(2'b11, {rnd_rec(), rnd_rec()}, 1'b0);
    drive(2'b10, {rnd_rec(), rnd_rec()}, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(4, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/difftest_commit_collector.md
Name: difftest_commit_collector

Overview:
- Producer side of the difftest instruction-commit path: gathers per-cycle ROB commit lanes, queues them, and drives one commit record per cycle to the InstrCommit difftest sink.
- Decouples the wide commit burst from the single-record sink, preserves program order, and tags each record with its original commit lane (index) and coreid.
- Sits between the ROB commit stage and the DPI sink instance.

Parameters:
- IN_LANES, 2, number of ROB commit lanes accepted per cycle (1..8).
- DEPTH, 16, queue entries; power of two, at least 2*IN_LANES.
- CORE_ID, 0, constant driven on out_coreid.
- REC_W, 150, localparam; record width, fixed.

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, asynchronous, active-high.
- in_valid, input, IN_LANES, per-lane commit valid. Lane 0 is oldest.
- in_rec, input, IN_LANES*REC_W, packed records; lane k at [k*REC_W +: REC_W].
- in_ready, output, 1, queue can absorb a full IN_LANES group this cycle.
- out_ready, input, 1, sink or batch logic accepts the head record.
- out_valid, output, 1, head record valid; connects to the sink enable/io_valid.
- out_rec, output, REC_W, head record.
- out_index, output, 8, source lane number of the head record, zero-extended.
- out_coreid, output, 8, CORE_ID.
- count, output, log2(DEPTH)+1, current occupancy.
- ovf_err, output, 1, sticky: commits were dropped.

Record layout (LSB first):
- pc[63:0], instr[95:64], robIdx[105:96], lqIdx[112:106], sqIdx[119:113]
- wdest[127:120], wpdest[135:128], nFused[143:136]
- skip[144], isRVC[145], rfwen[146], fpwen[147], isLoad[148], isStore[149]

Behaviour:
- Reset, asynchronous: head, tail, count = 0; ovf_err = 0. Outputs: out_valid = 0, in_ready = 1, out_index = 0. out_rec is don't-care while out_valid = 0. Reset asserted mid-operation discards all queued entries immediately.
- Storage: circular buffer of DEPTH entries, each REC_W + 3 bits (lane id). Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- in_ready = (DEPTH - count) >= IN_LANES, computed from registered count only. It deliberately ignores a same-cycle pop, so no combinational path exists from out_ready.
- Push when in_ready and any in_valid:
  - Valid lanes are compacted in ascending lane order into tail, tail+1, and so on. Gaps are allowed (e.g. only lane 1 valid → one entry with lane id 1).
  - tail advances by popcount(in_valid).
- Drop when any in_valid and !in_ready:
  - All lanes of that cycle are discarded.
  - ovf_err is set and stays 1 until reset.
  - count is unchanged except for a same-cycle pop.
- Output: out_valid = (count != 0). out_rec and out_index are read combinationally from mem[head].
  - Push-to-output latency is 1 cycle: a record written at edge t is visible after edge t.
  - The queue is not bypassed when empty.
- Pop when out_valid && out_ready: head advances by 1.
- Simultaneous push and pop: count_next = count + popcount(in_valid & {IN_LANES{in_ready}}) - pop. Both pointers update independently.
- Full and empty:
  - count never exceeds DEPTH.
  - out_ready while empty has no effect.
  - At count = DEPTH - IN_LANES + 1, in_ready = 0 even when a pop is occurring.
- Ordering: records leave in exact commit order, oldest cycle first and lane order within a cycle.
- The block never alters record contents.

Test Plan:
- Reset, then a single lane-0 commit with pc=0x80000000, instr=0x00000013 → next cycle: out_valid=1, out_rec.pc=0x80000000, out_index=0, count=1. With out_ready=1, count returns to 0 one cycle later.
- IN_LANES=2, both lanes valid for 4 consecutive cycles with pc incrementing by 4 and out_ready=1 → output pcs appear strictly ascending, one per cycle; out_index alternates 0,1; count peaks at 5.
- Only lane 1 valid with robIdx=0x3FF → a single record with out_index=1 and robIdx=0x3FF; no empty slot is emitted for lane 0.
- out_ready=0, fill with 2-lane pushes until count=15 → in_ready=0 once count reaches 15. A further in_valid=2'b11 sets ovf_err=1, count stays 15, and ovf_err stays 1 after draining.
- Wrap-around: DEPTH=16, push/pop continuously for 40 records → the output sequence matches the input order exactly across pointer wrap.
- Assert reset with count=7 mid-stream → count, out_valid and ovf_err go to 0 asynchronously, without waiting for a clock edge; no stale record appears after reset is released.
